// File: rtl/uart_pkg.sv
// Shared types and sizing helpers for the buffered UART and its FIFOs.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    // Occupancy counters need one extra bit so a full FIFO is distinguishable from an empty one.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; a pop in the same cycle frees a slot for a push into a full FIFO.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            push,
    input  logic [WIDTH-1:0]                push_data,
    input  logic                            pop,
    output logic [WIDTH-1:0]                head,
    output logic                            empty,
    output logic                            full,
    output logic [level_width(DEPTH)-1:0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [LW-1:0]    wr_ptr;
    logic [LW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign level   = wr_ptr - rd_ptr;
    assign empty   = (level == '0);
    assign full    = (level == LW'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_buffered_core.sv
// FIFO-buffered UART: baud tick generator, TX and RX frame engines, sticky receive error flags.
module uart_buffered_core
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 8,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [DIV_WIDTH-1:0]                 baud_div,
    input  logic [DATA_BITS-1:0]                 tx_data,
    input  logic                                 tx_valid,
    output logic                                 tx_ready,
    output logic [DATA_BITS-1:0]                 rx_data,
    output logic                                 rx_valid,
    input  logic                                 rx_ready,
    input  logic                                 err_clear,
    input  logic                                 uart_rx,
    output logic                                 uart_tx,
    output logic                                 tx_busy,
    output logic                                 rx_busy,
    output logic [level_width(FIFO_DEPTH)-1:0]   tx_level,
    output logic [level_width(FIFO_DEPTH)-1:0]   rx_level,
    output logic                                 rx_overrun,
    output logic                                 rx_frame_err,
    output logic                                 rx_parity_err
);

    localparam int CW = $clog2(2 * OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] BIT_LAST  = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS * OVERSAMPLE - 1);
    localparam logic [BW-1:0] IDX_LAST  = BW'(DATA_BITS - 1);

    logic [DIV_WIDTH-1:0] div_cnt;
    logic                 tick;

    logic [DATA_BITS-1:0] tx_head;
    logic                 tx_empty;
    logic                 tx_full;
    logic                 tx_start;
    uart_state_e          tx_state;
    logic [CW-1:0]        tx_cnt;
    logic [BW-1:0]        tx_idx;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_par;

    logic                 rx_s1;
    logic                 rx_s2;
    logic                 rx_prev;
    uart_state_e          rx_state;
    logic [CW-1:0]        rx_cnt;
    logic [BW-1:0]        rx_idx;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_par_bad;
    logic                 rx_sample;
    logic                 rx_push;
    logic                 rx_empty;
    logic                 rx_full;
    logic                 overrun_set;
    logic                 frame_set;
    logic                 parity_set;

    assign tick = (div_cnt == '0);

    // A new divisor is only picked up at reload, so a running bit period is never stretched mid-count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      div_cnt <= baud_div;
        else if (tick) div_cnt <= baud_div;
        else           div_cnt <= div_cnt - 1'b1;
    end

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (tx_valid && tx_ready),
        .push_data (tx_data),
        .pop       (tx_start),
        .head      (tx_head),
        .empty     (tx_empty),
        .full      (tx_full),
        .level     (tx_level)
    );

    assign tx_ready = !tx_full;
    assign tx_start = tick && !tx_empty &&
                      ((tx_state == IDLE) || (tx_state == STOP && tx_cnt == STOP_LAST));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state <= IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
            tx_busy  <= 1'b0;
            uart_tx  <= 1'b1;
        end else if (tx_start) begin
            tx_state <= START;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shift <= tx_head;
            tx_par   <= (^tx_head) ^ (PARITY_ODD != 0);
            tx_busy  <= 1'b1;
            uart_tx  <= 1'b0;
        end else if (tick) begin
            case (tx_state)
                START: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_state <= DATA;
                        tx_cnt   <= '0;
                        uart_tx  <= tx_shift[0];
                    end else tx_cnt <= tx_cnt + 1'b1;
                end
                DATA: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_idx == IDX_LAST) begin
                            tx_state <= (PARITY_EN != 0) ? PARITY : STOP;
                            uart_tx  <= (PARITY_EN != 0) ? tx_par : 1'b1;
                        end else begin
                            tx_idx   <= tx_idx + 1'b1;
                            tx_shift <= tx_shift >> 1;
                            uart_tx  <= tx_shift[1];
                        end
                    end else tx_cnt <= tx_cnt + 1'b1;
                end
                PARITY: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_state <= STOP;
                        tx_cnt   <= '0;
                        uart_tx  <= 1'b1;
                    end else tx_cnt <= tx_cnt + 1'b1;
                end
                STOP: begin
                    if (tx_cnt == STOP_LAST) begin
                        tx_state <= IDLE;
                        tx_cnt   <= '0;
                        tx_busy  <= 1'b0;
                    end else tx_cnt <= tx_cnt + 1'b1;
                end
                default: tx_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= uart_rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    // Every state after START samples once per bit, at the mid-bit point aligned by the half-bit START wait.
    assign rx_sample   = tick && (rx_cnt == BIT_LAST);
    assign rx_push     = rx_sample && (rx_state == STOP) && rx_s2 && !rx_par_bad;
    assign frame_set   = rx_sample && (rx_state == STOP) && !rx_s2;
    assign parity_set  = rx_sample && (rx_state == PARITY) &&
                         ((^rx_shift) ^ (PARITY_ODD != 0) ^ rx_s2);
    assign overrun_set = rx_push && rx_full && !(rx_valid && rx_ready);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state   <= IDLE;
            rx_cnt     <= '0;
            rx_idx     <= '0;
            rx_shift   <= '0;
            rx_par_bad <= 1'b0;
            rx_busy    <= 1'b0;
        end else begin
            case (rx_state)
                IDLE: begin
                    if (rx_prev && !rx_s2) begin
                        rx_state   <= START;
                        rx_cnt     <= '0;
                        rx_par_bad <= 1'b0;
                        rx_busy    <= 1'b1;
                    end
                end
                START: begin
                    if (tick && rx_cnt == HALF_LAST) begin
                        rx_cnt <= '0;
                        rx_idx <= '0;
                        if (rx_s2) begin
                            rx_state <= IDLE;
                            rx_busy  <= 1'b0;
                        end else rx_state <= DATA;
                    end else if (tick) rx_cnt <= rx_cnt + 1'b1;
                end
                DATA: begin
                    if (rx_sample) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
                        if (rx_idx == IDX_LAST) rx_state <= (PARITY_EN != 0) ? PARITY : STOP;
                        else                    rx_idx   <= rx_idx + 1'b1;
                    end else if (tick) rx_cnt <= rx_cnt + 1'b1;
                end
                PARITY: begin
                    if (rx_sample) begin
                        rx_cnt     <= '0;
                        rx_par_bad <= parity_set;
                        rx_state   <= STOP;
                    end else if (tick) rx_cnt <= rx_cnt + 1'b1;
                end
                STOP: begin
                    if (rx_sample) begin
                        rx_cnt   <= '0;
                        rx_state <= IDLE;
                        rx_busy  <= 1'b0;
                    end else if (tick) rx_cnt <= rx_cnt + 1'b1;
                end
                default: rx_state <= IDLE;
            endcase
        end
    end

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rx_push),
        .push_data (rx_shift),
        .pop       (rx_ready),
        .head      (rx_data),
        .empty     (rx_empty),
        .full      (rx_full),
        .level     (rx_level)
    );

    assign rx_valid = !rx_empty;

    // A flag event in the same cycle as err_clear must not be lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_overrun    <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_parity_err <= 1'b0;
        end else begin
            rx_overrun    <= overrun_set || (rx_overrun    && !err_clear);
            rx_frame_err  <= frame_set   || (rx_frame_err  && !err_clear);
            rx_parity_err <= parity_set  || (rx_parity_err && !err_clear);
        end
    end

endmodule

// File: tb/tb_uart_buffered_core.sv
// Directed bench: instance a is 8N1 at one clock per tick, instance b is 8O2 at two clocks per tick.
module tb_uart_buffered_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] a_baud, b_baud;
    logic [7:0]  a_tx_data, b_tx_data, a_rx_data, b_rx_data;
    logic        a_tx_valid, b_tx_valid, a_tx_ready, b_tx_ready;
    logic        a_rx_valid, b_rx_valid, a_rx_ready, b_rx_ready;
    logic        a_err_clear, b_err_clear, a_uart_rx, b_uart_rx, a_uart_tx, b_uart_tx;
    logic        a_tx_busy, b_tx_busy, a_rx_busy, b_rx_busy;
    logic [3:0]  a_tx_level, b_tx_level, a_rx_level, b_rx_level;
    logic        a_rx_overrun, b_rx_overrun, a_rx_frame_err, b_rx_frame_err;
    logic        a_rx_parity_err, b_rx_parity_err;
    logic        a_loop, b_loop, a_rx_drive, b_rx_drive;

    assign a_uart_rx = a_loop ? a_uart_tx : a_rx_drive;
    assign b_uart_rx = b_loop ? b_uart_tx : b_rx_drive;

    uart_buffered_core dut_a (
        .clk(clk), .rst(rst), .baud_div(a_baud),
        .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_ready(a_tx_ready),
        .rx_data(a_rx_data), .rx_valid(a_rx_valid), .rx_ready(a_rx_ready),
        .err_clear(a_err_clear), .uart_rx(a_uart_rx), .uart_tx(a_uart_tx),
        .tx_busy(a_tx_busy), .rx_busy(a_rx_busy),
        .tx_level(a_tx_level), .rx_level(a_rx_level),
        .rx_overrun(a_rx_overrun), .rx_frame_err(a_rx_frame_err), .rx_parity_err(a_rx_parity_err)
    );

    uart_buffered_core #(.PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst(rst), .baud_div(b_baud),
        .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready),
        .rx_data(b_rx_data), .rx_valid(b_rx_valid), .rx_ready(b_rx_ready),
        .err_clear(b_err_clear), .uart_rx(b_uart_rx), .uart_tx(b_uart_tx),
        .tx_busy(b_tx_busy), .rx_busy(b_rx_busy),
        .tx_level(b_tx_level), .rx_level(b_rx_level),
        .rx_overrun(b_rx_overrun), .rx_frame_err(b_rx_frame_err), .rx_parity_err(b_rx_parity_err)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives a serial frame LSB first onto the bench-driven RX line of instance a or b.
    task automatic applyStimulus(input bit to_b, input logic [11:0] frame, input int nbits, input int period);
        for (int i = 0; i < nbits; i++) begin
            if (to_b) b_rx_drive = frame[i];
            else      a_rx_drive = frame[i];
            step(period);
        end
        a_rx_drive = 1'b1;
        b_rx_drive = 1'b1;
    endtask

    task automatic pop_a(input string tag, input logic [7:0] exp);
        checkOutput({tag, "_valid"}, a_rx_valid, 1);
        checkOutput({tag, "_data"}, a_rx_data, exp);
        a_rx_ready = 1'b1;
        step(1);
        a_rx_ready = 1'b0;
    endtask

    task automatic wait_tx_a_idle(input string tag);
        int n;
        n = 0;
        while (a_tx_busy && n < 2000) begin
            step(1);
            n++;
        end
        checkOutput({tag, "_tx_done_in_time"}, (n < 2000), 1);
    endtask

    logic [7:0] burst [9];
    logic [7:0] got_b [3];
    logic [9:0] f55;

    // Pushes the nine burst bytes with a valid/ready handshake; returns the cycle of the first push.
    task automatic push_burst_a(input string tag, output int p0);
        int accepted;
        int n;
        logic rdy;
        accepted = 0;
        n = 0;
        p0 = 0;
        while (accepted < 9 && n < 20) begin
            a_tx_data  = burst[accepted];
            a_tx_valid = 1'b1;
            rdy = a_tx_ready;
            step(1);
            if (rdy) begin
                if (accepted == 0) p0 = cyc;
                accepted++;
            end
            n++;
        end
        a_tx_valid = 1'b0;
        checkOutput({tag, "_accepted"}, accepted, 9);
        checkOutput({tag, "_push_cycles"}, n, 9);
        checkOutput({tag, "_tx_level_full"}, a_tx_level, 8);
        checkOutput({tag, "_tx_ready_low"}, a_tx_ready, 0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int p0;
        int t9;
        int n;
        int ng;
        bit seen;

        rst = 1'b0;
        a_baud = 16'd0;  b_baud = 16'd1;
        a_tx_data = '0;  b_tx_data = '0;
        a_tx_valid = 0;  b_tx_valid = 0;
        a_rx_ready = 0;  b_rx_ready = 0;
        a_err_clear = 0; b_err_clear = 0;
        a_loop = 0;      b_loop = 0;
        a_rx_drive = 1;  b_rx_drive = 1;
        step(3);

        checkOutput("rst_uart_tx", a_uart_tx, 1);
        checkOutput("rst_tx_ready", a_tx_ready, 1);
        checkOutput("rst_rx_valid", a_rx_valid, 0);
        checkOutput("rst_tx_level", a_tx_level, 0);
        checkOutput("rst_rx_level", a_rx_level, 0);
        checkOutput("rst_tx_busy", a_tx_busy, 0);
        checkOutput("rst_rx_busy", a_rx_busy, 0);
        checkOutput("rst_flags", {a_rx_overrun, a_rx_frame_err, a_rx_parity_err}, 0);
        checkOutput("rst_b_uart_tx", b_uart_tx, 1);

        rst = 1'b1;
        step(2);
        checkOutput("idle_uart_tx", a_uart_tx, 1);

        // 0x55 frame: falls one edge after the push, 16 clocks per bit, busy for 160 clocks.
        a_loop = 1'b1;
        f55 = {1'b1, 8'h55, 1'b0};
        a_tx_data  = 8'h55;
        a_tx_valid = 1'b1;
        step(1);
        a_tx_valid = 1'b0;
        checkOutput("tx55_pre_fall", a_uart_tx, 1);
        step(1);
        checkOutput("tx55_busy_rise", a_tx_busy, 1);
        for (int i = 0; i < 160; i++) begin
            if ((i % 16) == 0 || (i % 16) == 15)
                checkOutput($sformatf("tx55_bit%0d_t%0d", i / 16, i % 16), a_uart_tx, f55[i / 16]);
            if (i == 159) checkOutput("tx55_busy_last", a_tx_busy, 1);
            step(1);
        end
        checkOutput("tx55_busy_fall", a_tx_busy, 0);
        checkOutput("tx55_line_idle", a_uart_tx, 1);
        checkOutput("tx55_rx_level", a_rx_level, 1);
        pop_a("tx55_loop", 8'h55);
        checkOutput("tx55_rx_empty", a_rx_valid, 0);

        // Nine back-to-back bytes looped back with rx_ready low: eight kept, ninth overruns.
        burst = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'hC3};
        push_burst_a("fill1", p0);
        wait_tx_a_idle("fill1");
        step(4);
        checkOutput("ovr1_rx_level", a_rx_level, 8);
        checkOutput("ovr1_overrun", a_rx_overrun, 1);
        checkOutput("ovr1_frame_err", a_rx_frame_err, 0);
        for (int i = 0; i < 8; i++) pop_a($sformatf("ovr1_byte%0d", i), burst[i]);
        checkOutput("ovr1_drained", a_rx_valid, 0);
        a_err_clear = 1'b1;
        step(1);
        a_err_clear = 1'b0;
        checkOutput("ovr1_cleared", a_rx_overrun, 0);

        // Same again, popping exactly in the cycle of the ninth push (fall + 8 frames + 155).
        burst = '{8'h5A, 8'hA5, 8'h3C, 8'hC3, 8'h0F, 8'hF0, 8'h96, 8'h69, 8'hE7};
        push_burst_a("fill2", p0);
        t9 = p0 + 1 + 8 * 160 + 155;
        n = 0;
        while (cyc < t9 - 1 && n < 3000) begin
            step(1);
            n++;
        end
        checkOutput("ovr2_pre9_level", a_rx_level, 8);
        a_rx_ready = 1'b1;
        step(1);
        a_rx_ready = 1'b0;
        wait_tx_a_idle("fill2");
        step(4);
        checkOutput("ovr2_rx_level", a_rx_level, 8);
        checkOutput("ovr2_no_overrun", a_rx_overrun, 0);
        for (int i = 1; i < 9; i++) pop_a($sformatf("ovr2_byte%0d", i), burst[i]);

        // Three-clock glitch: RX wakes up, rejects at half-bit, reports nothing.
        a_loop = 1'b0;
        step(2);
        a_rx_drive = 1'b0;
        step(3);
        a_rx_drive = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (a_rx_busy) seen = 1'b1;
            step(1);
        end
        checkOutput("glitch_busy_seen", seen, 1);
        step(10);
        checkOutput("glitch_busy_end", a_rx_busy, 0);
        checkOutput("glitch_no_byte", a_rx_valid, 0);
        checkOutput("glitch_no_flag", {a_rx_overrun, a_rx_frame_err, a_rx_parity_err}, 0);

        // Stop bit forced low, then a clean frame of the same byte.
        applyStimulus(1'b0, {2'b00, 1'b0, 8'h5C, 1'b0}, 10, 16);
        step(20);
        checkOutput("ferr_flag", a_rx_frame_err, 1);
        checkOutput("ferr_dropped", a_rx_valid, 0);
        checkOutput("ferr_no_parity", a_rx_parity_err, 0);
        a_err_clear = 1'b1;
        step(1);
        a_err_clear = 1'b0;
        checkOutput("ferr_cleared", a_rx_frame_err, 0);
        applyStimulus(1'b0, {2'b00, 1'b1, 8'h5C, 1'b0}, 10, 16);
        step(20);
        checkOutput("good_no_ferr", a_rx_frame_err, 0);
        pop_a("good_rx", 8'h5C);

        // Instance b loopback with odd parity and two stop bits.
        b_loop = 1'b1;
        b_rx_ready = 1'b1;
        b_tx_valid = 1'b1;
        b_tx_data = 8'hA3; step(1);
        b_tx_data = 8'h00; step(1);
        b_tx_data = 8'hFF; step(1);
        b_tx_valid = 1'b0;
        ng = 0;
        n = 0;
        while (ng < 3 && n < 3000) begin
            if (b_rx_valid) begin
                got_b[ng] = b_rx_data;
                ng++;
            end
            step(1);
            n++;
        end
        checkOutput("loop_count", ng, 3);
        checkOutput("loop_byte0", got_b[0], 8'hA3);
        checkOutput("loop_byte1", got_b[1], 8'h00);
        checkOutput("loop_byte2", got_b[2], 8'hFF);
        checkOutput("loop_flags", {b_rx_overrun, b_rx_frame_err, b_rx_parity_err}, 0);
        b_rx_ready = 1'b0;
        n = 0;
        while (b_tx_busy && n < 1000) begin
            step(1);
            n++;
        end
        checkOutput("loop_tx_done", b_tx_busy, 0);
        b_loop = 1'b0;
        step(4);

        // 0x01 has one set bit, so odd parity sends 0; sending 1 must be rejected.
        applyStimulus(1'b1, {2'b11, 1'b0, 8'h01, 1'b0}, 12, 32);
        step(10);
        checkOutput("par_ok_valid", b_rx_valid, 1);
        checkOutput("par_ok_data", b_rx_data, 8'h01);
        checkOutput("par_ok_flag", b_rx_parity_err, 0);
        b_rx_ready = 1'b1;
        step(1);
        b_rx_ready = 1'b0;
        applyStimulus(1'b1, {2'b11, 1'b1, 8'h01, 1'b0}, 12, 32);
        step(10);
        checkOutput("par_bad_flag", b_rx_parity_err, 1);
        checkOutput("par_bad_dropped", b_rx_valid, 0);
        checkOutput("par_bad_no_ferr", b_rx_frame_err, 0);

        // Reset in the middle of the first data bit of 0x96 with a second byte still queued.
        a_tx_valid = 1'b1;
        a_tx_data = 8'h96; step(1);
        a_tx_data = 8'h3C; step(1);
        a_tx_valid = 1'b0;
        step(20);
        checkOutput("mid_busy", a_tx_busy, 1);
        checkOutput("mid_level", a_tx_level, 1);
        checkOutput("mid_line_low", a_uart_tx, 0);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("abort_uart_tx", a_uart_tx, 1);
        checkOutput("abort_tx_level", a_tx_level, 0);
        checkOutput("abort_tx_busy", a_tx_busy, 0);
        checkOutput("abort_tx_ready", a_tx_ready, 1);
        #3;
        rst = 1'b1;
        step(3);
        checkOutput("after_abort_line", a_uart_tx, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
